// File: rtl/jtframe_dwnld_pack.sv
// jtframe_dwnld_pack
// ------------------
// ROM download packer. Bytes from the ioctl stream are queued with their
// address in a small FIFO and then written to the SDRAM programming port one
// byte lane at a time, using a prog_we / prog_ack handshake. dwnld_busy
// covers the download itself, the draining of queued bytes and a settling
// tail of TAIL cycles after the last write.
//
// Optional feature (macro JTFRAME_DWNLD_HEADER_EN): the first HEADER strobes
// of each download are consumed without being written, and later bytes are
// written at ioctl_addr - HEADER. Leave the macro undefined for raw addressing.
//
// Parameters
//   ADDRW   ioctl byte-address width
//   DEPTH   FIFO entries (power of two, >= 2)
//   TAIL    cycles dwnld_busy stays high after draining (>= 1)
//   HEADER  bytes skipped per download (header build only)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   downloading  high while a ROM download is in progress
//   ioctl_addr   byte address of ioctl_data
//   ioctl_data   download byte
//   ioctl_wr     one-cycle byte strobe
//   prog_addr    SDRAM word address
//   prog_data    byte to write
//   prog_mask    active-low byte enables (2'b10 lower lane, 2'b01 upper lane)
//   prog_we      write request, held until prog_ack
//   prog_ack     SDRAM controller accepted the request
//   dwnld_busy   download or trailing writes in progress
//   overflow     sticky: a byte was dropped on a full FIFO

module jtframe_dwnld_pack #(
  parameter int ADDRW  = 22,
  parameter int DEPTH  = 4,
  parameter int TAIL   = 16,
  parameter int HEADER = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             downloading,
  input  logic [ADDRW-1:0] ioctl_addr,
  input  logic [7:0]       ioctl_data,
  input  logic             ioctl_wr,
  output logic [ADDRW-1:0] prog_addr,
  output logic [7:0]       prog_data,
  output logic [1:0]       prog_mask,
  output logic             prog_we,
  input  logic             prog_ack,
  output logic             dwnld_busy,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TAIL > 1) ? $clog2(TAIL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  state_t           state;
  logic [TW-1:0]    tail_cnt;

  logic [ADDRW+7:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [ADDRW+7:0] rd_entry;
  logic [ADDRW-1:0] rd_addr;

  logic             dl_q;
  logic             dl_rise;
  logic             strobe;
  logic             accept;
  logic [ADDRW-1:0] push_addr;
  logic             push, pop, drop;

  assign dl_rise  = downloading & ~dl_q;
  assign strobe   = ioctl_wr & downloading;
  assign rd_entry = mem[rd_ptr];
  assign rd_addr  = rd_entry[ADDRW+7:8];

`ifdef JTFRAME_DWNLD_HEADER_EN
  localparam int HW = (HEADER > 0) ? $clog2(HEADER + 1) : 1;

  logic [HW-1:0] hdr_cnt;
  logic [HW-1:0] hdr_base;
  logic          in_header;

  // The counter restarts on the rising edge of downloading; a strobe on that
  // same edge is already the first byte of the new download.
  assign hdr_base  = dl_rise ? '0 : hdr_cnt;
  assign in_header = hdr_base < HW'(HEADER);
  assign accept    = strobe & ~in_header;
  assign push_addr = ioctl_addr - ADDRW'(HEADER);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_cnt <= '0;
    end else if (strobe && in_header) begin
      hdr_cnt <= hdr_base + HW'(1);
    end else begin
      hdr_cnt <= hdr_base;
    end
  end
`else
  assign accept    = strobe;
  assign push_addr = ioctl_addr;
`endif

  // A push into a full FIFO is still accepted when a pop frees a slot on the
  // same edge; only a push with no room at all is dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (count != '0 && !prog_we) pop = 1'b1;
    if (accept) begin
      if (count != CW'(DEPTH) || pop) push = 1'b1;
      else                            drop = 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count are reset, so
  // stale entries are never read and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_addr, ioctl_data};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the value from before the edge.
    if (!rst_n) begin
      dl_q      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
    end else begin
      dl_q <= downloading;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (dl_rise) overflow <= 1'b0;
      if (drop)    overflow <= 1'b1;

      // Pop only while no request is pending, which also guarantees one idle
      // cycle between consecutive requests.
      if (pop) begin
        prog_we   <= 1'b1;
        prog_addr <= {1'b0, rd_addr[ADDRW-1:1]};
        prog_data <= rd_entry[7:0];
        prog_mask <= rd_addr[0] ? 2'b01 : 2'b10;
      end else if (prog_we && prog_ack) begin
        prog_we   <= 1'b0;
        prog_mask <= 2'b11;
      end
    end
  end

  // Busy sequencer. dwnld_busy is updated together with the state so it is a
  // registered copy of (state != ST_IDLE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tail_cnt   <= '0;
      dwnld_busy <= 1'b0;
    end else if (downloading) begin
      state      <= ST_LOAD;
      dwnld_busy <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: dwnld_busy <= 1'b0;
        ST_LOAD: state <= ST_DRAIN;
        ST_DRAIN: begin
          if (count == '0 && !prog_we) begin
            state    <= ST_TAIL;
            tail_cnt <= TW'(TAIL - 1);
          end
        end
        ST_TAIL: begin
          if (tail_cnt == '0) begin
            state      <= ST_IDLE;
            dwnld_busy <= 1'b0;
          end else begin
            tail_cnt <= tail_cnt - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed testbench for jtframe_dwnld_pack (default parameters). Inputs are
// driven and outputs sampled 1 ns after each rising edge. Accepted writes
// (prog_we and prog_ack both high ahead of an edge) are logged as
// {prog_addr, prog_data, prog_mask} and compared against hand-computed lists.
// With JTFRAME_DWNLD_HEADER_EN defined only the reset and header scenarios run.

module tb_jtframe_dwnld_pack;

  logic        clk;
  logic        rst_n;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack;
  logic        dwnld_busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] obs_q[$];

  jtframe_dwnld_pack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .prog_ack    (prog_ack),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && prog_we === 1'b1 && prog_ack === 1'b1)
      obs_q.push_back({prog_addr, prog_data, prog_mask});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [21:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dwnld_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (dwnld_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: dwnld_busy=%b required 0", tag, dwnld_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (prog_we !== 1'b0) begin
      errors++; $display("FAIL reset_we: got %b required 0", prog_we);
    end
    checks++;
    if (prog_addr !== 22'h0 || prog_data !== 8'h00) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h required 0/0", prog_addr, prog_data);
    end
    checks++;
    if (prog_mask !== 2'b11) begin
      errors++; $display("FAIL reset_mask: got %b required 11", prog_mask);
    end
    checks++;
    if (dwnld_busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_busy_ovf: got %b/%b required 0/0", dwnld_busy, overflow);
    end
  endtask

  task automatic test_single_byte();
    prog_ack    = 1'b1;
    downloading = 1'b1;
    tick();
    strobe(22'h000005, 8'hA5);           // edge k
    checks++;
    if (prog_we !== 1'b0) begin
      errors++; $display("FAIL single_early_we: got %b required 0", prog_we);
    end
    tick();                               // edge k+1
    checks++;
    if (prog_we !== 1'b1 || prog_addr !== 22'h000002 || prog_mask !== 2'b01 || prog_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_request: we/addr/mask/data got %b/%h/%b/%h required 1/000002/01/a5",
               prog_we, prog_addr, prog_mask, prog_data);
    end
    tick();                               // edge k+2: ack sampled
    checks++;
    if (prog_we !== 1'b0 || prog_mask !== 2'b11) begin
      errors++; $display("FAIL single_release: we/mask got %b/%b required 0/11", prog_we, prog_mask);
    end
    downloading = 1'b0;
    wait_idle("single");
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp;
    obs_q.delete();
    prog_ack    = 1'b0;
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) strobe(22'h20 + 22'(i), 8'h30 + 8'(i));
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL bp_overflow: got %b required 1", overflow);
    end
    checks++;
    if (prog_we !== 1'b1 || prog_addr !== 22'h10 || prog_mask !== 2'b10 || prog_data !== 8'h30) begin
      errors++;
      $display("FAIL bp_held: we/addr/mask/data got %b/%h/%b/%h required 1/000010/10/30",
               prog_we, prog_addr, prog_mask, prog_data);
    end
    prog_ack = 1'b1;
    repeat (30) tick();
    checks++;
    if (obs_q.size() != 5) begin
      errors++; $display("FAIL bp_write_count: got %0d required 5", obs_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      logic [21:0] a;
      a   = 22'h20 + 22'(i);
      exp = {1'b0, a[21:1], 8'h30 + 8'(i), (a[0] ? 2'b01 : 2'b10)};
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp) begin
        errors++;
        $display("FAIL bp_write[%0d]: got %h required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, exp);
      end
    end
    downloading = 1'b0;
    wait_idle("bp");
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL bp_overflow_sticky: got %b required 1", overflow);
    end
  endtask

  task automatic test_full_with_pop();
    logic [31:0] exp;
    obs_q.delete();
    prog_ack    = 1'b0;
    downloading = 1'b1;
    tick();                               // rising edge clears overflow
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fp_overflow_clear: got %b required 0", overflow);
    end
    for (int i = 0; i < 5; i++) strobe(22'h40 + 22'(i), 8'h50 + 8'(i));
    prog_ack = 1'b1;
    tick();                               // request released, FIFO still full
    strobe(22'h45, 8'h55);                // push and pop on the same edge
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fp_no_drop: overflow got %b required 0", overflow);
    end
    repeat (30) tick();
    checks++;
    if (obs_q.size() != 6) begin
      errors++; $display("FAIL fp_write_count: got %0d required 6", obs_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      logic [21:0] a;
      a   = 22'h40 + 22'(i);
      exp = {1'b0, a[21:1], 8'h50 + 8'(i), (a[0] ? 2'b01 : 2'b10)};
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp) begin
        errors++;
        $display("FAIL fp_write[%0d]: got %h required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, exp);
      end
    end
    downloading = 1'b0;
    wait_idle("fp");
  endtask

  task automatic test_busy_tail();
    logic [31:0] exp_w [4];
    exp_w[0] = {22'h08, 8'h60, 2'b10};
    exp_w[1] = {22'h08, 8'h61, 2'b01};
    exp_w[2] = {22'h09, 8'h62, 2'b10};
    exp_w[3] = {22'h09, 8'h63, 2'b01};
    obs_q.delete();
    prog_ack    = 1'b0;
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) strobe(22'h10 + 22'(i), 8'h60 + 8'(i));
    downloading = 1'b0;
    for (int w = 0; w < 4; w++) begin
      int n = 0;
      while (prog_we !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (prog_we !== 1'b1) begin
        errors++; $display("FAIL tail_req[%0d]: prog_we got %b required 1", w, prog_we);
      end
      prog_ack = 1'b1;
      tick();                             // last iteration: edge m
      prog_ack = 1'b0;
    end
    repeat (16) tick();                   // edge m+16
    checks++;
    if (dwnld_busy !== 1'b1) begin
      errors++; $display("FAIL tail_busy_m16: got %b required 1", dwnld_busy);
    end
    tick();                               // edge m+17
    checks++;
    if (dwnld_busy !== 1'b0) begin
      errors++; $display("FAIL tail_busy_m17: got %b required 0", dwnld_busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL tail_write[%0d]: got %h required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, exp_w[i]);
      end
    end
  endtask

  task automatic test_retrigger();
    logic dropped = 1'b0;
    prog_ack    = 1'b1;
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    tick();                               // edge d: LOAD -> DRAIN
    tick();                               // edge d+1: TAIL, count 15
    for (int i = 0; i < 10; i++) begin
      if (dwnld_busy !== 1'b1) dropped = 1'b1;
      tick();
    end
    checks++;
    if (dut.tail_cnt !== 4'd5) begin
      errors++; $display("FAIL retrig_tail_cnt: got %0d required 5", dut.tail_cnt);
    end
    downloading = 1'b1;
    tick();                               // edge d+12
    checks++;
    if (dut.state !== 2'd1) begin         // ST_LOAD
      errors++; $display("FAIL retrig_state: got %0d required 1", dut.state);
    end
    for (int i = 0; i < 20; i++) begin
      if (dwnld_busy !== 1'b1) dropped = 1'b1;
      tick();
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++; $display("FAIL retrig_busy_drop: dropped=%b required 0", dropped);
    end
    downloading = 1'b0;
    tick();                               // edge d2: DRAIN
    repeat (16) tick();
    checks++;
    if (dwnld_busy !== 1'b1) begin
      errors++; $display("FAIL retrig_busy_d16: got %b required 1", dwnld_busy);
    end
    tick();
    checks++;
    if (dwnld_busy !== 1'b0) begin
      errors++; $display("FAIL retrig_busy_d17: got %b required 0", dwnld_busy);
    end
  endtask

  task automatic test_mid_reset();
    int we_seen = 0;
    prog_ack    = 1'b0;
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) strobe(22'h80 + 22'(i), 8'h90 + 8'(i));
    checks++;
    if (prog_we !== 1'b1) begin
      errors++; $display("FAIL mr_pending: prog_we got %b required 1", prog_we);
    end
    rst_n       = 1'b0;
    downloading = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (prog_we !== 1'b0 || prog_addr !== 22'h0 || prog_data !== 8'h00 || prog_mask !== 2'b11) begin
      errors++;
      $display("FAIL mr_outputs: we/addr/data/mask got %b/%h/%h/%b required 0/000000/00/11",
               prog_we, prog_addr, prog_data, prog_mask);
    end
    checks++;
    if (dwnld_busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mr_busy_ovf: got %b/%b required 0/0", dwnld_busy, overflow);
    end
    prog_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (prog_we === 1'b1) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      errors++; $display("FAIL mr_no_request: prog_we cycles got %0d required 0", we_seen);
    end
  endtask

`ifdef JTFRAME_DWNLD_HEADER_EN
  task automatic test_header();
    logic [31:0] exp_w [2];
    exp_w[0] = {22'h0, 8'h40, 2'b10};
    exp_w[1] = {22'h0, 8'h41, 2'b01};
    obs_q.delete();
    prog_ack    = 1'b1;
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 66; i++) strobe(22'(i), 8'(i));
    repeat (10) tick();
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL hdr_write_count: got %0d required 2", obs_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL hdr_write[%0d]: got %h required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, exp_w[i]);
      end
    end
    downloading = 1'b0;
    wait_idle("hdr");
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_data  = '0;
    ioctl_wr    = 1'b0;
    prog_ack    = 1'b0;

    test_reset();
`ifdef JTFRAME_DWNLD_HEADER_EN
    test_header();
`else
    test_single_byte();
    test_back_pressure();
    test_full_with_pop();
    test_busy_tail();
    test_retrigger();
    test_mid_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtframe_dwnld_pack.md
# jtframe_dwnld_pack

ROM download packer between the MiSTer framework's ioctl byte stream and the SDRAM programming port. Captures each downloaded byte with its address into a small FIFO, then issues byte-lane SDRAM write requests (`prog_addr`/`prog_data`/`prog_mask`/`prog_we`) with a request/acknowledge handshake. Generates `dwnld_busy`, which holds the game in reset until the last byte has been written and a settling tail has elapsed. Sits inside the framework, upstream of the SDRAM controller and the game's `prog_*` inputs.

## Interface
- `ADDRW`, 22: ioctl byte-address width.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `TAIL`, 16: clk cycles `dwnld_busy` stays high after drain completes, ≥1.
- `HEADER`, 64: bytes skipped per download; used only with `JTFRAME_DWNLD_HEADER_EN`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `downloading`  in  1  high for the duration of a ROM download.
- `ioctl_addr`  in  ADDRW  byte address of `ioctl_data`.
- `ioctl_data`  in  8  download byte.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `prog_addr`  out  ADDRW  SDRAM word address.
- `prog_data`  out  8  byte to write, replicated on both lanes by the controller.
- `prog_mask`  out  2  active-low byte enables.
- `prog_we`  out  1  write request, held until acknowledged.
- `prog_ack`  in  1  SDRAM controller accepted the request.
- `dwnld_busy`  out  1  download or trailing writes in progress.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Reset (`rst_n`=0 sampled): FIFO flushed, count=0. `prog_we`=0, `prog_addr`=0, `prog_data`=0, `prog_mask`=2'b11, `dwnld_busy`=0, `overflow`=0, state IDLE. Applies mid-transfer; a pending request is abandoned.
- Push: edge with `ioctl_wr`=1 and `downloading`=1 stores {`ioctl_addr`,`ioctl_data`}. Strobes while `downloading`=0 are ignored.
- Full: push while count==DEPTH and no pop on that edge → byte dropped, `overflow`←1. `overflow` clears only on the rising edge of `downloading` or on reset.
- Pop: edge with count>0 and `prog_we`=0 → `prog_we`←1, `prog_addr`←{1'b0, addr[ADDRW-1:1]}, `prog_data`←data, `prog_mask`←addr[0] ? 2'b01 : 2'b10. Even byte → lower lane.
- Simultaneous push and pop → count unchanged; a push into a full FIFO with a pop on the same edge is accepted.
- Handshake: `prog_we` and its outputs stay stable until an edge samples `prog_ack`=1, after which `prog_we`←0 and `prog_mask`←2'b11. `prog_ack` while `prog_we`=0 is ignored. One idle cycle always separates requests.
- FSM:
  - IDLE (`dwnld_busy`=0) → LOAD when `downloading`=1.
  - LOAD → DRAIN when `downloading`=0.
  - DRAIN → TAIL when count==0 and `prog_we`=0; the tail counter loads TAIL-1.
  - TAIL decrements each cycle and goes to IDLE after the cycle at 0.
  - Any state → LOAD when `downloading`=1; the tail counter is discarded.
- `dwnld_busy` = (state≠IDLE), registered.

## Timing
- Byte sampled at edge k with an empty FIFO and `prog_we`=0 → `prog_we` high after edge k+1.
- `prog_ack` sampled at edge m → `prog_we` low after m. The next request can assert after edge m+1 at the earliest.
- Sustained throughput is one byte per 2 cycles plus the controller's ack latency.
- Last write acknowledged at edge m with the FIFO empty → DRAIN→TAIL at m+1; `dwnld_busy` falls after edge m+1+TAIL.
- `downloading` falls while the FIFO is empty and idle → `dwnld_busy` falls TAIL+1 cycles later.

## Configuration
- `JTFRAME_DWNLD_HEADER_EN` defined:
  - A byte counter resets on the rising edge of `downloading`.
  - The first HEADER strobes are consumed and not pushed; they do not count toward overflow.
  - Later bytes push with address `ioctl_addr`−HEADER.
- Undefined: every strobe is pushed with the raw address and the counter is not built.

## Test plan
- Single byte: `ioctl_addr`=0x000005, data=0xA5, `prog_ack` tied 1 → after one cycle, `prog_we`=1 with `prog_addr`=0x000002, `prog_mask`=2'b01, `prog_data`=0xA5, for exactly 1 cycle.
- Back-pressure: `prog_ack`=0, strobe 6 bytes with DEPTH=4 → 1 request held, 4 queued, 1 dropped, `overflow`=1. Release `prog_ack` → 5 writes issued in address order; `overflow` stays 1 until the next `downloading` rise.
- Busy tail: 4 bytes, `downloading` falls, last ack at edge m → `dwnld_busy` low exactly after edge m+17 (TAIL=16).
- Re-trigger: `downloading` re-rises during TAIL count 5 → `dwnld_busy` never drops; state goes to LOAD.
- Mid-transfer reset: `rst_n`=0 for 1 edge with `prog_we`=1 and 3 queued → all outputs return to reset values, and no further `prog_we` occurs without new strobes.
- Header (macro on, HEADER=64): 66 bytes at addresses 0..65 → exactly 2 writes, `prog_addr`=0 with masks 2'b10 then 2'b01.
